sub_chunk_serial: RTL and testbench
===================================

# sub_chunk_serial

- Chunk-serial subtractor: computes A = C − B over an N-bit word, streamed least-significant chunk first as CC chunks of W = N/CC bits, one chunk per accepted transfer.
- It is the inverse counterpart of the chunk-serial adder.
  - It recovers one operand from a sum and the other operand.
  - It reports the final borrow, i.e. the C < B underflow, at the end of each word.
- It sits downstream of the serial sum datapath, with valid/ready handshakes on both sides.
- A chunk counter frames words so that the borrow is cleared automatically at each word boundary.

## Interface

Parameters:
- N, default 256: total operand width in bits.
- CC, default 64: chunks per word. N must be divisible by CC.
- W, default N/CC (4): chunk width. Derived; do not override.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  reset. Synchronous, active-low.
- in_valid  in  1  the input chunk is valid.
- in_ready  out  1  the block can accept an input chunk.
- c  in  W  minuend chunk (sum).
- b  in  W  subtrahend chunk.
- out_valid  out  1  the output chunk is valid.
- out_ready  in  1  the downstream consumer accepts the output.
- a  out  W  difference chunk.
- first  out  1  the output chunk is chunk 0 of a word.
- last  out  1  the output chunk is chunk CC−1 of a word.
- borrow_out  out  1  final borrow of the word. Meaningful only when last=1; 0 otherwise.
- chunk_idx  out  clog2(CC)  index of the current output chunk.

## Operation

- Input acceptance: in_fire = in_valid & in_ready.
- Output transfer: out_fire = out_valid & out_ready.
- Ready rule: in_ready = !out_valid | out_ready, combinational.
  - The output stage is one register deep.
  - Accept and drain in the same cycle are permitted.
- State:
  - borrow register, 1 bit.
  - in_cnt, the input chunk counter over 0..CC−1.
  - Output register holding a, first, last, borrow_out and chunk_idx.
- On each in_fire:
  - {bw, d} = {1'b0, c} − {1'b0, b} − borrow, computed at W+1 bits. bw is the borrow out of the chunk.
  - Load a ← d, chunk_idx ← in_cnt, first ← (in_cnt==0), last ← (in_cnt==CC−1).
  - If in_cnt==CC−1:
    - borrow_out ← bw.
    - borrow ← 0.
    - in_cnt ← 0.
  - Otherwise:
    - borrow_out ← 0.
    - borrow ← bw.
    - in_cnt ← in_cnt+1.
  - out_valid ← 1.
- On out_fire without in_fire: out_valid ← 0.
- Without in_fire, the output register, borrow and in_cnt all hold.
- The borrow used for chunk 0 is always 0; no carry-in port exists.
- Arithmetic is unsigned modulo 2^N per word. Underflow is reported only through borrow_out on the last chunk.
- Word framing runs purely on in_cnt. There is no start or abort input. A partial word is discarded only by reset.
- When CC=1, every chunk is both first and last, and borrow is never carried.

## Timing

- Latency: 1 cycle. A chunk accepted at edge k is presented with out_valid=1 after edge k.
- Throughput: 1 chunk/cycle while out_ready=1. One word takes CC accepted transfers.
- Backpressure:
  - out_valid=1 and out_ready=0 forces in_ready=0.
  - a and the flags hold stable until out_fire.
- Reset (rst=0 at an edge) sets:
  - out_valid=0, a=0, first=0, last=0, borrow_out=0, chunk_idx=0.
  - borrow=0, in_cnt=0.
- While rst=0, in_ready is 1, because out_valid=0. No input is accepted while rst=0.
- Reset mid-word abandons the partial word. The next accepted chunk is chunk 0 with borrow 0.
- in_valid and the input data may change freely while in_ready=0. They are sampled only on in_fire.

## Test plan

All scenarios use N=8, CC=2, W=4 unless stated otherwise.

- Basic with inter-chunk borrow: 0x23 − 0x15 as (c=3, b=5) then (c=2, b=1).
  - Outputs: a=0xE (first=1, chunk_idx=0), then a=0x0 (last=1, borrow_out=0). Word result 0x0E.
- Underflow: 0x10 − 0x20.
  - Outputs: a=0x0, then a=0xF with last=1, borrow_out=1.
- Borrow cleared at word boundary: underflow word as above, immediately followed by 0x11 − 0x01.
  - Second word outputs: a=0x0, a=0x1, borrow_out=0. No stale borrow leaks in.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1.
  - in_ready=0 throughout; a and the flags stay stable.
  - After out_ready rises, there are back-to-back transfers with no lost or duplicated chunk.
- Reset mid-word: accept chunk 0 (c=0, b=1, giving borrow 1), then pulse rst=0 for one cycle, then send 0x55 − 0x22.
  - out_valid=0 after reset.
  - Outputs: a=0x3 (first=1), then 0x3 with borrow_out=0.
- Default parameters (N=256, CC=64): random 200-word stream with random in_valid/out_ready stalls.
  - Reassembled A matches (C − B) mod 2^256.
  - borrow_out matches C < B for every word.

Source files
------------

// File: rtl/sub_chunk_serial_if.sv
// sub_chunk_serial_if
// -------------------
// Bundles the upstream (input chunk) and downstream (output chunk) handshake
// and data signals of the chunk-serial subtractor.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. The sender holds valid and its data stable until that edge.
// The receiver may raise or lower ready at any time. Data is sampled only on
// a transfer edge.
//
// Parameters:
//   W     chunk width in bits
//   IDXW  width of chunk_idx
//
// Signals:
//   in_valid / in_ready   input chunk handshake (c = minuend, b = subtrahend)
//   out_valid / out_ready output chunk handshake
//   a                     difference chunk
//   first / last          output chunk is chunk 0 / chunk CC-1 of a word
//   borrow_out            final word borrow, only set alongside last
//   chunk_idx             position of the output chunk within its word
//
// Modports:
//   master  environment view: drives the input chunk and out_ready
//   slave   subtractor view
interface sub_chunk_serial_if #(
   parameter int W    = 4,
   parameter int IDXW = 6
);
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    c;
   logic [W-1:0]    b;
   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    a;
   logic            first;
   logic            last;
   logic            borrow_out;
   logic [IDXW-1:0] chunk_idx;

   modport master (
      output in_valid, c, b, out_ready,
      input  in_ready, out_valid, a, first, last, borrow_out, chunk_idx
   );

   modport slave (
      input  in_valid, c, b, out_ready,
      output in_ready, out_valid, a, first, last, borrow_out, chunk_idx
   );
endinterface

// File: rtl/sub_chunk_serial.sv
// sub_chunk_serial
// ----------------
// Chunk-serial subtractor: A = C - B over an N-bit word, streamed least
// significant chunk first as CC chunks of W bits. The borrow is carried
// between chunks of a word and cleared at each word boundary; the final
// borrow (C < B) is reported with the last chunk of the word.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active low
//   bus   sub_chunk_serial_if.slave: input chunk handshake (c, b) and output
//         chunk handshake (a, first, last, borrow_out, chunk_idx)
//
// The output stage is a single register; in_ready lets a new chunk in
// whenever that register is empty or being drained in the same cycle.
module sub_chunk_serial #(
   parameter int N    = 256,
   parameter int CC   = 64,
   parameter int W    = N / CC,
   parameter int IDXW = (CC > 1) ? $clog2(CC) : 1
) (
   input  logic               clk,
   input  logic               rst,
   sub_chunk_serial_if.slave  bus
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CC - 1);

   // State
   logic            borrow_q,     borrow_d;
   logic [IDXW-1:0] in_cnt_q,     in_cnt_d;
   logic            out_valid_q,  out_valid_d;
   logic [W-1:0]    a_q,          a_d;
   logic            first_q,      first_d;
   logic            last_q,       last_d;
   logic            borrow_out_q, borrow_out_d;
   logic [IDXW-1:0] chunk_idx_q,  chunk_idx_d;

   // Datapath / handshake helpers
   logic            in_ready;
   logic            in_fire;
   logic            out_fire;
   logic            cnt_last;
   logic [W:0]      diff;

   always_comb begin
      in_ready = !out_valid_q || bus.out_ready;
      in_fire  = bus.in_valid && in_ready;
      out_fire = out_valid_q && bus.out_ready;
      cnt_last = (in_cnt_q == LAST_IDX);
      // W+1 bit subtraction: the top bit is the borrow out of this chunk.
      diff     = {1'b0, bus.c} - {1'b0, bus.b} - {{W{1'b0}}, borrow_q};
   end

   always_comb begin
      borrow_d     = borrow_q;
      in_cnt_d     = in_cnt_q;
      out_valid_d  = out_valid_q;
      a_d          = a_q;
      first_d      = first_q;
      last_d       = last_q;
      borrow_out_d = borrow_out_q;
      chunk_idx_d  = chunk_idx_q;

      if (in_fire) begin
         a_d         = diff[W-1:0];
         chunk_idx_d = in_cnt_q;
         first_d     = (in_cnt_q == '0);
         last_d      = cnt_last;
         out_valid_d = 1'b1;
         if (cnt_last) begin
            // End of word: publish the borrow and start the next word clean.
            borrow_out_d = diff[W];
            borrow_d     = 1'b0;
            in_cnt_d     = '0;
         end else begin
            borrow_out_d = 1'b0;
            borrow_d     = diff[W];
            in_cnt_d     = in_cnt_q + IDXW'(1);
         end
      end else if (out_fire) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         borrow_q     <= 1'b0;
         in_cnt_q     <= '0;
         out_valid_q  <= 1'b0;
         a_q          <= '0;
         first_q      <= 1'b0;
         last_q       <= 1'b0;
         borrow_out_q <= 1'b0;
         chunk_idx_q  <= '0;
      end else begin
         borrow_q     <= borrow_d;
         in_cnt_q     <= in_cnt_d;
         out_valid_q  <= out_valid_d;
         a_q          <= a_d;
         first_q      <= first_d;
         last_q       <= last_d;
         borrow_out_q <= borrow_out_d;
         chunk_idx_q  <= chunk_idx_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.a          = a_q;
   assign bus.first      = first_q;
   assign bus.last       = last_q;
   assign bus.borrow_out = borrow_out_q;
   assign bus.chunk_idx  = chunk_idx_q;

endmodule

// File: tb/tb_sub_chunk_serial.sv
// tb_sub_chunk_serial
// -------------------
// Bench for sub_chunk_serial. A small instance (N=8, CC=2) takes the
// directed scenarios; a default instance (N=256, CC=64) takes a random
// 200-word stream with random stalls on both sides, checked against whole
// word arithmetic (C - B mod 2^256, C < B).
module tb_sub_chunk_serial;

   logic clk;
   logic rst;

   // -------------------------------------------------------------- clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   sub_chunk_serial_if #(.W(4), .IDXW(1)) bus_s ();
   sub_chunk_serial_if #(.W(4), .IDXW(6)) bus_d ();

   sub_chunk_serial #(.N(8), .CC(2)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (bus_s.slave)
   );

   sub_chunk_serial dut_d (
      .clk (clk),
      .rst (rst),
      .bus (bus_d.slave)
   );

   int n_pass  = 0;
   int n_total = 0;

   // -------------------------------------------------------------- checking
   task automatic check(input string tag, input logic [256:0] obs,
                        input logic [256:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Small-instance snapshot: {out_valid, a, first, last, borrow_out, chunk_idx}
   function automatic logic [8:0] snap_s();
      return {bus_s.out_valid, bus_s.a, bus_s.first, bus_s.last,
              bus_s.borrow_out, bus_s.chunk_idx};
   endfunction

   function automatic logic [8:0] exp_s(input logic ov, input logic [3:0] a,
                                        input logic f, input logic l,
                                        input logic bo, input logic idx);
      return {ov, a, f, l, bo, idx};
   endfunction

   // -------------------------------------------------------------- drivers
   // One accepted chunk on the small instance with out_ready held high,
   // then the registered output is checked one cycle later.
   task automatic s_xfer(input string tag, input logic [3:0] cv,
                         input logic [3:0] bv, input logic [3:0] ea,
                         input logic ef, input logic el, input logic eb,
                         input logic ei);
      @(posedge clk); #1;
      bus_s.in_valid  = 1'b1;
      bus_s.c         = cv;
      bus_s.b         = bv;
      bus_s.out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_in_ready"}, 257'(bus_s.in_ready), 257'(1'b1));
      @(posedge clk); #1;
      bus_s.in_valid = 1'b0;
      check(tag, 257'(snap_s()), 257'(exp_s(1'b1, ea, ef, el, eb, ei)));
   endtask

   // -------------------------------------------------------------- scoreboard
   localparam int DW     = 256;
   localparam int DCC    = 64;
   localparam int NWORDS = 200;

   logic [DW:0] exp_q[$];
   int          words_done = 0;
   logic        drv_abort  = 1'b0;

   task automatic drive_words();
      logic [DW-1:0] cw, bw;
      int            mode;
      for (int w = 0; w < NWORDS && !drv_abort; w++) begin
         for (int i = 0; i < DW / 32; i++) begin
            cw[i*32 +: 32] = $urandom();
            bw[i*32 +: 32] = $urandom();
         end
         mode = $urandom_range(0, 7);
         if (mode == 0) bw = cw;                        // exact zero result
         if (mode == 1) begin cw = '0; bw = 1; end      // minimal underflow
         if (mode == 2) begin cw = '1; bw = '0; end     // no borrow anywhere
         if (mode == 3) begin cw = '0; bw = '1; end     // borrow ripples all chunks
         exp_q.push_back({cw < bw, cw - bw});
         for (int k = 0; k < DCC; k++) begin
            int tries = 0;
            forever begin
               @(posedge clk); #1;
               bus_d.in_valid = ($urandom_range(0, 3) != 0);
               bus_d.c        = cw[k*4 +: 4];
               bus_d.b        = bw[k*4 +: 4];
               @(negedge clk);
               if (bus_d.in_valid && bus_d.in_ready) break;
               tries++;
               if (tries > 200) break;
            end
            if (tries > 200) begin
               check("d_input_stall_bound", 257'(tries), 257'(200));
               drv_abort = 1'b1;
               break;
            end
         end
      end
      @(posedge clk); #1;
      bus_d.in_valid = 1'b0;
   endtask

   task automatic monitor_words();
      logic [DW-1:0] acc;
      logic [DW:0]   exp_w;
      int            k = 0;
      acc = '0;
      for (int cyc = 0; cyc < 60000 && words_done < NWORDS; cyc++) begin
         @(posedge clk); #1;
         bus_d.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (bus_d.out_valid && bus_d.out_ready) begin
            check("d_chunk_flags",
                  257'({bus_d.first, bus_d.last, bus_d.chunk_idx,
                        bus_d.last ? 1'b0 : bus_d.borrow_out}),
                  257'({k == 0, k == DCC - 1, 6'(k), 1'b0}));
            acc[k*4 +: 4] = bus_d.a;
            k++;
            if (k == DCC) begin
               if (exp_q.size() == 0) begin
                  check("d_unexpected_word", 257'(1), 257'(0));
               end else begin
                  exp_w = exp_q.pop_front();
                  check("d_word_a", 257'(acc), 257'(exp_w[DW-1:0]));
                  check("d_word_borrow", 257'(bus_d.borrow_out), 257'(exp_w[DW]));
               end
               words_done++;
               k   = 0;
               acc = '0;
            end
         end
      end
      check("d_words_received", 257'(words_done), 257'(NWORDS));
   endtask

   // -------------------------------------------------------------- sequence
   initial begin
      rst             = 1'b0;
      bus_s.in_valid  = 1'b0;
      bus_s.c         = '0;
      bus_s.b         = '0;
      bus_s.out_ready = 1'b1;
      bus_d.in_valid  = 1'b0;
      bus_d.c         = '0;
      bus_d.b         = '0;
      bus_d.out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("s_reset_state", 257'(snap_s()), 257'(0));
      check("s_reset_in_ready", 257'(bus_s.in_ready), 257'(1'b1));
      check("d_reset_state",
            257'({bus_d.out_valid, bus_d.a, bus_d.first, bus_d.last,
                  bus_d.borrow_out, bus_d.chunk_idx}), 257'(0));
      rst = 1'b1;

      // 0x23 - 0x15 = 0x0E with an inter-chunk borrow
      s_xfer("basic_c0", 4'h3, 4'h5, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0);
      s_xfer("basic_c1", 4'h2, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);

      // 0x10 - 0x20 underflows, then 0x11 - 0x01 must start borrow-free
      s_xfer("under_c0", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      s_xfer("under_c1", 4'h1, 4'h2, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1);
      s_xfer("clean_c0", 4'h1, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      s_xfer("clean_c1", 4'h1, 4'h0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1);

      // Backpressure: 0x74 - 0x21 = 0x53, held for 3 cycles after chunk 0
      @(posedge clk); #1;                     // previous output drains here
      check("bp_idle", 257'(bus_s.out_valid), 257'(1'b0));
      bus_s.in_valid  = 1'b1;
      bus_s.c         = 4'h4;
      bus_s.b         = 4'h1;
      bus_s.out_ready = 1'b0;
      @(posedge clk); #1;                     // chunk 0 accepted
      for (int i = 0; i < 3; i++) begin
         bus_s.c = 4'($urandom_range(0, 15)); // ignored while stalled
         bus_s.b = 4'($urandom_range(0, 15));
         #1;
         check("bp_in_ready_low", 257'(bus_s.in_ready), 257'(1'b0));
         check("bp_hold", 257'(snap_s()),
               257'(exp_s(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0)));
         @(posedge clk); #1;
      end
      check("bp_hold_final", 257'(snap_s()),
            257'(exp_s(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0)));
      bus_s.c         = 4'h7;
      bus_s.b         = 4'h2;
      bus_s.out_ready = 1'b1;
      #1;
      check("bp_release_ready", 257'(bus_s.in_ready), 257'(1'b1));
      @(posedge clk); #1;                     // drain chunk 0, accept chunk 1
      bus_s.in_valid = 1'b0;
      check("bp_c1", 257'(snap_s()),
            257'(exp_s(1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1)));
      @(posedge clk); #1;
      check("bp_drained", 257'(bus_s.out_valid), 257'(1'b0));

      // Reset mid-word abandons the pending borrow
      s_xfer("rst_c0", 4'h0, 4'h1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("rst_in_ready", 257'(bus_s.in_ready), 257'(1'b1));
      @(posedge clk); #1;
      check("rst_cleared", 257'(snap_s()), 257'(0));
      rst = 1'b1;
      s_xfer("post_rst_c0", 4'h5, 4'h2, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
      s_xfer("post_rst_c1", 4'h5, 4'h2, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1);

      // Random stream on the default-parameter instance
      fork
         drive_words();
         monitor_words();
      join
      check("d_queue_empty", 257'(exp_q.size()), 257'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
